// File: rtl/regwrite_port_arbiter_if.sv
// Writeback request/response bundle between the two writeback sources and the register-file port.
// The master side is the requesters plus the register file. The slave side is the arbiter.
interface regwrite_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sel;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, sel, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, sel, conflict_cnt
    );
endinterface

// File: rtl/regwrite_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (req0) and load/link (req1) writebacks.
// The write port is registered, so a write lands one cycle after its request is accepted.
module regwrite_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    regwrite_port_arbiter_if.slave bus
);
    logic              w_both;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    logic              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_sel;
    logic [CNT_W-1:0]  r_cnt;

    assign w_both = bus.req0_valid & bus.req1_valid;

    // On a tie, the requester that did not win last time gets the grant. Reset forces both grants low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst) begin
            if (w_both) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else begin
                w_gnt0 = bus.req0_valid;
                w_gnt1 = bus.req1_valid;
            end
        end
    end

    assign w_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
    assign w_data = w_gnt1 ? bus.req1_data : bus.req0_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_sel        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last_grant <= w_gnt1;
                r_sel        <= w_gnt1;
                r_wr_addr    <= w_addr;
                r_wr_data    <= w_data;
                // x0 is hardwired: such a request is consumed but never written.
                r_wr_en      <= (w_addr != '0);
            end else begin
                r_wr_en <= 1'b0;
            end
            if (w_both && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.req0_ready   = w_gnt0;
    assign bus.req1_ready   = w_gnt1;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.sel          = r_sel;
    assign bus.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Directed bench for regwrite_port_arbiter: a vector table followed by hand-written saturation and reset sequences.
module tb_regwrite_port_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int NV     = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [DATA_W-1:0] rf [32];

    regwrite_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    regwrite_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // This is a model of the register file that the write port feeds.
    always @(posedge clk)
        if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        sel;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1,
                                logic r0, logic r1, logic en, logic [4:0] addr,
                                logic [31:0] data, logic sel, logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.en = en; v.addr = addr; v.data = data; v.sel = sel; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v0, logic [4:0] a0, logic [31:0] d0,
                         logic v1, logic [4:0] a1, logic [31:0] d1);
        rst = r;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Columns: rst, v0, a0, d0, v1, a1, d1 | ready0, ready1 | after the edge: en, addr, data, sel, cnt
        vecs[0]  = mk(1, 1, 5, 32'h55, 0, 0, 0,                    0, 0, 0, 0, 32'h0, 0, 0);
        vecs[1]  = mk(1, 1, 5, 32'h55, 0, 0, 0,                    0, 0, 0, 0, 32'h0, 0, 0);
        vecs[2]  = mk(0, 1, 5, 32'h55, 0, 0, 0,                    1, 0, 1, 5, 32'h55, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 5, 32'h55, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,      1, 1, 32'hDEADBEEF,         0, 1, 1, 1, 32'hDEADBEEF, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
        vecs[6]  = mk(0, 1, 3, 32'h30, 1, 7, 32'h70,               1, 0, 1, 3, 32'h30, 0, 1);
        vecs[7]  = mk(0, 1, 3, 32'h30, 1, 7, 32'h70,               0, 1, 1, 7, 32'h70, 1, 2);
        vecs[8]  = mk(0, 1, 3, 32'h30, 1, 7, 32'h70,               1, 0, 1, 3, 32'h30, 0, 3);
        vecs[9]  = mk(0, 1, 3, 32'h30, 1, 7, 32'h70,               0, 1, 1, 7, 32'h70, 1, 4);
        vecs[10] = mk(0, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 7, 32'h70, 1, 4);
        vecs[11] = mk(1, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 0, 32'h0, 0, 0);
        vecs[12] = mk(0, 1, 9, 32'h1,  1, 9, 32'h2,                1, 0, 1, 9, 32'h1, 0, 1);
        vecs[13] = mk(0, 0, 0, 0,      1, 9, 32'h2,                0, 1, 1, 9, 32'h2, 1, 1);
        vecs[14] = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,              1, 0, 0, 0, 32'hFFFFFFFF, 0, 1);
        vecs[15] = mk(0, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 0, 32'hFFFFFFFF, 0, 1);
        // The x0 grant still went to req0, so on the next tie req1 must win.
        vecs[16] = mk(0, 1, 4, 32'h4,  1, 6, 32'h6,                0, 1, 1, 6, 32'h6, 1, 2);
        vecs[17] = mk(0, 0, 0, 0,      0, 0, 0,                    0, 0, 0, 6, 32'h6, 1, 2);

        for (int k = 0; k < 32; k++) rf[k] = '0;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            @(posedge clk); #1;
            chk($sformatf("v%0d wr_en", i),   32'(bus.wr_en),        32'(vecs[i].en));
            chk($sformatf("v%0d wr_addr", i), 32'(bus.wr_addr),      32'(vecs[i].addr));
            chk($sformatf("v%0d wr_data", i), bus.wr_data,           vecs[i].data);
            chk($sformatf("v%0d sel", i),     32'(bus.sel),          32'(vecs[i].sel));
            chk($sformatf("v%0d cnt", i),     32'(bus.conflict_cnt), 32'(vecs[i].cnt));
            if (i == 14) chk("same-addr final reg9", rf[9], 32'h2);
        end

        // Hold contention for 300 cycles. The count starts at 2, so it must reach 255 and then stay there.
        begin
            logic exp_g1;
            exp_g1 = 1'b0;
            drive(0, 1, 3, 32'h33, 1, 7, 32'h77);
            for (int c = 1; c <= 300; c++) begin
                @(negedge clk);
                if (c % 50 == 1) begin
                    chk($sformatf("rr c%0d ready0", c), 32'(bus.req0_ready), 32'(!exp_g1));
                    chk($sformatf("rr c%0d ready1", c), 32'(bus.req1_ready), 32'(exp_g1));
                end
                @(posedge clk); #1;
                exp_g1 = ~exp_g1;
                if (c == 252) chk("cnt before sat", 32'(bus.conflict_cnt), 32'd254);
                if (c == 253) chk("cnt at sat",     32'(bus.conflict_cnt), 32'd255);
            end
            chk("cnt saturated", 32'(bus.conflict_cnt), 32'd255);
            chk("pending write", 32'(bus.wr_en), 32'd1);
        end

        // A write is pending in the output register. Reset must drop it.
        drive(1, 1, 3, 32'h33, 1, 7, 32'h77);
        @(negedge clk);
        chk("rst ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst wr_en", 32'(bus.wr_en),        32'd0);
        chk("midrst cnt",   32'(bus.conflict_cnt), 32'd0);
        chk("midrst sel",   32'(bus.sel),          32'd0);

        // After the release, the first tie goes to req0.
        drive(0, 1, 3, 32'h33, 1, 7, 32'h77);
        @(negedge clk);
        chk("post-rst ready0", 32'(bus.req0_ready), 32'd1);
        chk("post-rst ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        chk("post-rst wr_addr", 32'(bus.wr_addr), 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regwrite_port_arbiter.md
Name: regwrite_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 is the ALU result path and req1 is the load/link path.
- Drives the 5-bit write-address mux select (sel) and registered write-port signals.
- Uses a round-robin grant, one grant per cycle, and a valid/ready handshake.
- Keeps a saturating count of contention cycles for performance debug.

Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register write data width
- CNT_W, 8, contention counter width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  ALU writeback request
- req0_addr  input  ADDR_W  ALU destination register
- req0_data  input  DATA_W  ALU result
- req0_ready  output  1  req0 accepted this cycle (combinational)
- req1_valid  input  1  load/link writeback request
- req1_addr  input  ADDR_W  load/link destination register
- req1_data  input  DATA_W  load/link data
- req1_ready  output  1  req1 accepted this cycle (combinational)
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  ADDR_W  register-file write address (registered)
- wr_data  output  DATA_W  register-file write data (registered)
- sel  output  1  address/data mux select: 0 = req0, 1 = req1 (registered)
- conflict_cnt  output  CNT_W  saturating count of cycles with both requests valid

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_en=0, wr_addr=0, wr_data=0, sel=0, conflict_cnt=0.
  - last_grant=1, so req0 wins the first tie.
  - While rst=1, req0_ready=req1_ready=0 and no request is consumed.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready.
  - Requesters hold valid, addr and data stable until accepted.
  - ready never depends on a future cycle.
- Grant logic (combinational, rst=0):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester opposite to last_grant.
  - Neither valid: no grant.
  - reqN_ready equals grant N. At most one ready is high per cycle.
- Grant registers (next clock edge after a grant):
  - last_grant <= granted index.
  - sel <= granted index.
  - wr_addr and wr_data <= the granted requester's values.
  - wr_en <= 1, unless the granted addr == 0.
- Write latency is exactly 1 cycle from acceptance to wr_en.
- Register 0:
  - A request to addr 0 is accepted (ready=1) and consumed.
  - It produces wr_en=0; wr_addr, wr_data and sel still update.
  - last_grant still updates.
- No grant in a cycle:
  - wr_en <= 0.
  - wr_addr, wr_data, sel and last_grant hold their previous values.
- Sustained contention: grants strictly alternate 0,1,0,1…, so neither requester waits more than 1 cycle.
- Same destination address on both in one cycle: the winner writes first and the loser writes on the following cycle. The loser's value is final in the register file.
- conflict_cnt increments by 1 on each edge where both valids are high (rst=0) and saturates at all-ones (255) with no wrap.
- Reset mid-operation:
  - An accepted request whose write is pending in the output register is dropped; wr_en=0 after the reset edge.
  - Requesters must re-present their requests after reset deasserts.

Test Plan:
- Reset check: assert rst 2 cycles with req0_valid=1, addr=5 → ready=0 throughout; wr_en=0, sel=0, conflict_cnt=0; first cycle after release grants req0 and the following cycle shows wr_en=1, wr_addr=5.
- Single requester: req1_valid=1, addr=5'b00001, data=32'hDEADBEEF for 1 cycle → req1_ready=1 same cycle; next cycle wr_en=1, wr_addr=1, wr_data=DEADBEEF, sel=1; the cycle after, wr_en=0.
- Contention round-robin: both valid for 4 cycles (addr0=3, addr1=7), re-presenting after acceptance → grants 0,1,0,1; sel sequence 0,1,0,1; conflict_cnt=4.
- Same address: req0 (addr 9, data 1) and req1 (addr 9, data 2) valid together after reset → write data 1 then data 2 on consecutive cycles; final reg9=2.
- Register 0: req0_valid, addr=0, data=32'hFFFFFFFF → req0_ready=1; next cycle wr_en=0, sel=0.
- Saturation and mid-op reset: both valid for 300 cycles → conflict_cnt=255; then assert rst the cycle after an accept → wr_en=0 and conflict_cnt=0 after the edge.
